// File: rtl/ram_pkg.sv
// Shared defaults and FSM state type for the banked RAM.
// Keeping them here lets the top and the storage agree on widths without duplication.
package ram_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADR_W_DEF  = 16;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/ram_array.sv
// Word storage with one byte-masked synchronous write port and one synchronous read port.
// Only the read data register is reset; the memory itself is cleared by the owner's fill.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W  = ADR_W_DEF
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                i_we,
  input  logic [ADR_W-1:0]    i_wadr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wbe,
  input  logic                i_re,
  input  logic [ADR_W-1:0]    i_radr,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-masked write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_wadr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register: loads only on an accepted read so a stalled response stays put.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rdata <= {DATA_W{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_radr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_ram.sv
// Single-port RAM front end: post-reset zero fill, request handshake and a
// one-entry read response register with backpressure.
module banked_ram
  import ram_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADR_W      = ADR_W_DEF,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic                reqWrite,
  input  logic [ADR_W-1:0]    adr,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [DATA_W/8-1:0] byteEn,
  output logic                readValid,
  input  logic                rspReady,
  output logic [DATA_W-1:0]   readData,
  output logic                initDone
);

  localparam int NB = DATA_W / 8;

  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("banked_ram: DATA_W must be a multiple of 8");
  end

  state_t            r_state;
  logic [ADR_W-1:0]  r_cnt;
  logic              r_init_done;
  logic              r_rvalid;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_we;
  logic [ADR_W-1:0]  w_wadr;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_wbe;

  // A held, unconsumed response blocks new requests so it cannot be overwritten.
  assign reqReady = r_init_done & ~(r_rvalid & ~rspReady);
  assign w_rd_acc = reqValid & reqReady & ~reqWrite;
  assign w_wr_acc = reqValid & reqReady & reqWrite;

  // Write port steering: fill engine owns the port during INIT, requests otherwise.
  always_comb begin
    w_we    = 1'b0;
    w_wadr  = adr;
    w_wdata = writeData;
    w_wbe   = byteEn;
    if ((r_state == ST_INIT) && INIT_CLEAR) begin
      w_we    = 1'b1;
      w_wadr  = r_cnt;
      w_wdata = {DATA_W{1'b0}};
      w_wbe   = {NB{1'b1}};
    end else begin
      w_we    = w_wr_acc;
    end
  end

  // Control FSM: fill sequencing, init flag and response-valid tracking.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= ST_INIT;
      r_cnt       <= {ADR_W{1'b0}};
      r_init_done <= 1'b0;
      r_rvalid    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_rvalid <= 1'b0;
          if (INIT_CLEAR) begin
            r_cnt <= r_cnt + ADR_W'(1'b1);
            if (r_cnt == {ADR_W{1'b1}}) begin
              r_state     <= ST_IDLE;
              r_init_done <= 1'b1;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_init_done <= 1'b1;
          if (w_rd_acc) begin
            r_rvalid <= 1'b1;
          end else if (rspReady) begin
            r_rvalid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_INIT;
          r_cnt       <= {ADR_W{1'b0}};
          r_init_done <= 1'b0;
          r_rvalid    <= 1'b0;
        end
      endcase
    end
  end

  assign readValid = r_rvalid;
  assign initDone  = r_init_done;

  ram_array #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W)
  ) u_array (
    .clk     (clk),
    .rstN    (rstN),
    .i_we    (w_we),
    .i_wadr  (w_wadr),
    .i_wdata (w_wdata),
    .i_wbe   (w_wbe),
    .i_re    (w_rd_acc),
    .i_radr  (adr),
    .o_rdata (readData)
  );

endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 Parameter DATA_W, default 64, meaning data word width in bits; SHALL be a multiple of 8, otherwise elaboration SHALL fail.
REQ-002 Parameter ADR_W, default 16, meaning address width; depth SHALL be 2**ADR_W words.
REQ-003 Parameter INIT_CLEAR, default 1, meaning 1 = zero-fill all words after reset, 0 = no fill.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rstN  input  1  reset, asynchronous assert, active-low.
REQ-006 reqValid  input  1  request present.
REQ-007 reqReady  output  1  request can be accepted this cycle.
REQ-008 reqWrite  input  1  1 = write, 0 = read.
REQ-009 adr  input  ADR_W  word address.
REQ-010 writeData  input  DATA_W  write data.
REQ-011 byteEn  input  DATA_W/8  per-byte write enable; bit i covers bits 8i+7:8i.
REQ-012 readValid  output  1  readData holds a response.
REQ-013 rspReady  input  1  consumer accepts the response.
REQ-014 readData  output  DATA_W  read response data.
REQ-015 initDone  output  1  zero-fill finished; block in service.

Function
REQ-016 A request SHALL be accepted on a rising edge where reqValid and reqReady are both 1.
REQ-017 reqReady SHALL equal initDone AND NOT (readValid AND NOT rspReady).
REQ-018 An accepted write SHALL update only the bytes whose byteEn bit is 1; a write with byteEn all-zero SHALL leave memory unchanged.
REQ-019 Writes SHALL produce no response and SHALL NOT affect readValid.
REQ-020 An accepted read SHALL assert readValid with readData = mem[adr] on the edge following acceptance (latency 1).
REQ-021 readValid and readData SHALL hold stable while readValid is 1 and rspReady is 0.
REQ-022 When readValid and rspReady are both 1 with no new read accepted, readValid SHALL drop on the next edge.
REQ-023 Response retired and new read accepted on the same edge SHALL give back-to-back readValid at one read per cycle.
REQ-024 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-025 FSM states SHALL be INIT and IDLE; reset SHALL enter INIT.
REQ-026 In INIT with INIT_CLEAR=1, an ADR_W-bit counter SHALL write zero to word counter, one word per cycle, from 0 to 2**ADR_W-1.
REQ-027 The transition INIT->IDLE SHALL occur on the edge that writes the last word; initDone SHALL be 1 from that edge onward.
REQ-028 With INIT_CLEAR=0, INIT SHALL last exactly one cycle and perform no writes.
REQ-029 Requests presented during INIT SHALL be ignored, since reqReady is 0.

Reset
REQ-030 While rstN is 0: reqReady=0, readValid=0, initDone=0, readData=0, state=INIT, counter=0.
REQ-031 Reset asserted mid-fill or mid-response SHALL abort immediately; a pending response SHALL be discarded.
REQ-032 Memory contents SHALL NOT be reset directly; they are cleared only by the INIT fill.

Structure
REQ-033 Package ram_pkg SHALL hold the DATA_W and ADR_W defaults and the INIT/IDLE state enum typedef.
REQ-034 Sub-module ram_array SHALL contain the storage, the byte-masked synchronous write and the synchronous read port; banked_ram SHALL contain the FSM, counter and handshake.

Verification (bench: DATA_W=64, ADR_W=4, INIT_CLEAR=1)
REQ-035 Release reset -> initDone=1 exactly 16 cycles later; reading all 16 addresses returns 0.
REQ-036 Write adr=3, data=0x1122334455667788, byteEn=0xFF; then write adr=3, data=0xAAAAAAAAAAAAAAAA, byteEn=0x0F; read adr=3 -> 0x11223344AAAAAAAA, 1-cycle latency.
REQ-037 Read adr=3 with rspReady=0 for 5 cycles -> readValid and readData held stable, reqReady=0; raise rspReady -> readValid drops next edge.
REQ-038 Reads to adr 0,1,2 on consecutive cycles with rspReady=1 -> three consecutive readValid cycles with matching data.
REQ-039 Assert rstN=0 at fill count 7 and release it -> initDone=0, fill restarts at address 0, and initDone=1 16 cycles after release.
REQ-040 Present reqValid=1 with a write during INIT -> no memory change and reqReady=0.
